// File: rtl/prio_pkg.sv
// Shared definitions for the two-level priority encoder pipeline.
// Holds the default parameter values and the helper functions that derive
// the index and count widths. Each use site builds its own result struct
// from idx_w().
package prio_pkg;

   localparam int DEF_WIDTH     = 8;
   localparam bit DEF_MSB_FIRST = 1'b1;

   // Width of a bit index into a vector of the given width.
   function automatic int idx_w(input int width);
      return $clog2(width);
   endfunction

   // Width needed to hold a set-bit count from 0 up to the given width.
   function automatic int cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/prio_find1.sv
// Combinational single-level priority find.
// Returns the absolute position of the highest-priority set bit in vec.
// MSB_FIRST selects whether the top bit or bit 0 wins. When vec is all
// zero, none is raised and idx reads as 0.
module prio_find1
   import prio_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter bit MSB_FIRST  = DEF_MSB_FIRST,
   localparam int IW        = idx_w(WIDTH)
) (
   input  logic [WIDTH-1:0] vec,
   output logic [IW-1:0]    idx,
   output logic             none
);

   // Scan toward the winning end so that the last hit seen is the winner.
   always_comb begin
      // NOTE: every output gets a default before the loop; otherwise a path
      // with no hit leaves idx unassigned and a latch is inferred.
      idx  = '0;
      none = ~|vec;
      if (MSB_FIRST) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) idx = IW'(i);
         end
      end else begin
         for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) idx = IW'(i);
         end
      end
   end

endmodule

// File: rtl/prio2_enc_pipe.sv
// Two-stage pipelined first/second priority encoder with valid/ready
// handshakes on both sides.
// Stage 1 captures the vector and its first hit; stage 2 masks that hit
// out, finds the second, and holds the results in the output registers.
// Optional feature: define PRIO2_POPCNT_EN to add the popcnt output,
// the number of set bits, carried alongside the result.
module prio2_enc_pipe
   import prio_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter bit MSB_FIRST  = DEF_MSB_FIRST,
   localparam int IW        = idx_w(WIDTH)
`ifdef PRIO2_POPCNT_EN
   , localparam int CW      = cnt_w(WIDTH)
`endif
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_vec,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IW-1:0]    first_idx,
   output logic             first_none,
   output logic [IW-1:0]    second_idx,
   output logic             second_none
`ifdef PRIO2_POPCNT_EN
   , output logic [CW-1:0]  popcnt
`endif
);

   typedef struct packed {
      logic [IW-1:0] idx;
      logic          none;
   } prio_res_t;

   logic             s1_valid;
   logic [WIDTH-1:0] s1_vec;
   prio_res_t        s1_first;

   logic             s1_load;
   logic             s2_load;

   logic [IW-1:0]    find1_idx;
   logic             find1_none;
   logic [WIDTH-1:0] s2_masked;
   logic [IW-1:0]    find2_idx;
   logic             find2_none;

   // A stage loads when its downstream slot is free or draining this cycle,
   // so a full pipeline still accepts one vector per cycle.
   assign s2_load  = !out_valid || out_ready;
   assign s1_load  = !s1_valid || s2_load;
   assign in_ready = s1_load;

   // Stage 1 find on the incoming vector.
   prio_find1 #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_find_first (
      .vec  (in_vec),
      .idx  (find1_idx),
      .none (find1_none)
   );

   // Stage 2 find on the stored vector with its first hit cleared. An empty
   // vector stays empty after masking, so the second result is also none.
   assign s2_masked = s1_vec & ~(WIDTH'(1) << s1_first.idx);

   prio_find1 #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_find_second (
      .vec  (s2_masked),
      .idx  (find2_idx),
      .none (find2_none)
   );

`ifdef PRIO2_POPCNT_EN
   logic [CW-1:0] cnt_c;
   logic [CW-1:0] s1_cnt;

   // Count the set bits of the incoming vector alongside the stage-1 find.
   always_comb begin
      cnt_c = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (in_vec[i]) cnt_c = cnt_c + CW'(1);
      end
   end

   // Carry the count through stage 1, capturing only on an input transfer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_cnt <= '0;
      end else if (s1_load && in_valid) begin
         s1_cnt <= cnt_c;
      end
   end

   // Output count moves with the other results and holds while stalled.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         popcnt <= '0;
      end else if (s2_load && s1_valid) begin
         popcnt <= s1_cnt;
      end
   end
`endif

   // Stage 1 register: capture on transfer, bubble when nothing arrives.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values, whatever the block order.
         s1_valid      <= 1'b0;
         s1_vec        <= '0;
         s1_first.idx  <= '0;
         s1_first.none <= 1'b1;
      end else if (s1_load) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_vec        <= in_vec;
            s1_first.idx  <= find1_idx;
            s1_first.none <= find1_none;
         end
      end
   end

   // Output registers: load from stage 1 when the downstream slot is free.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid   <= 1'b0;
         first_idx   <= '0;
         first_none  <= 1'b1;
         second_idx  <= '0;
         second_none <= 1'b1;
      end else if (s2_load) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            first_idx   <= s1_first.idx;
            first_none  <= s1_first.none;
            second_idx  <= find2_idx;
            second_none <= find2_none;
         end
      end
   end

endmodule

// File: tb/tb_prio2_enc_pipe.sv
// Bench for prio2_enc_pipe: one 8-bit MSB-first instance (a_*) and one
// 16-bit LSB-first instance (b_*). Expected results are pushed when an
// input transfer is seen and popped when an output transfer is seen.
// Define PRIO2_POPCNT_EN to also cover the popcnt output.
module tb_prio2_enc_pipe;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [7:0]  a_in_vec;
   logic [2:0]  a_first_idx, a_second_idx;
   logic        a_first_none, a_second_none;
   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [15:0] b_in_vec;
   logic [3:0]  b_first_idx, b_second_idx;
   logic        b_first_none, b_second_none;
`ifdef PRIO2_POPCNT_EN
   logic [3:0]  a_popcnt;
   logic [4:0]  b_popcnt;
`endif

   prio2_enc_pipe #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut_a (
      .clk(clk), .reset_n(reset_n),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_vec(a_in_vec),
      .out_valid(a_out_valid), .out_ready(a_out_ready),
      .first_idx(a_first_idx), .first_none(a_first_none),
      .second_idx(a_second_idx), .second_none(a_second_none)
`ifdef PRIO2_POPCNT_EN
      , .popcnt(a_popcnt)
`endif
   );

   prio2_enc_pipe #(.WIDTH(16), .MSB_FIRST(1'b0)) u_dut_b (
      .clk(clk), .reset_n(reset_n),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_vec(b_in_vec),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .first_idx(b_first_idx), .first_none(b_first_none),
      .second_idx(b_second_idx), .second_none(b_second_none)
`ifdef PRIO2_POPCNT_EN
      , .popcnt(b_popcnt)
`endif
   );

   typedef struct {
      logic [15:0] v;
      logic [3:0]  fi;
      logic        fn;
      logic [3:0]  si;
      logic        sn;
      logic [4:0]  pc;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   int   total  = 0;
   int   passed = 0;
   int   cyc    = 0;
   int   a_seen = 0;
   int   b_seen = 0;

   always @(posedge clk) cyc++;

   // Reference: walk from the winning end, first hit then second hit.
   function automatic exp_t model(input logic [15:0] v, input int w, input bit msb);
      exp_t e;
      int   found;
      int   pos;
      e = '{v: v, fi: 4'd0, fn: 1'b1, si: 4'd0, sn: 1'b1, pc: 5'd0};
      found = 0;
      for (int k = 0; k < w; k++) begin
         pos = msb ? (w - 1 - k) : k;
         if (v[pos]) begin
            if (found == 0) begin
               e.fi = 4'(pos);
               e.fn = 1'b0;
            end else if (found == 1) begin
               e.si = 4'(pos);
               e.sn = 1'b0;
            end
            found++;
         end
      end
      e.pc = 5'(found);
      return e;
   endfunction

   // Input monitors: an input transfer happens at the next rising edge.
   always @(negedge clk) begin
      if (reset_n && a_in_valid && a_in_ready) qa.push_back(model({8'h00, a_in_vec}, 8, 1'b1));
      if (reset_n && b_in_valid && b_in_ready) qb.push_back(model(b_in_vec, 16, 1'b0));
   end

   // Output monitor, instance a.
   always @(negedge clk) begin
      if (reset_n && a_out_valid && a_out_ready) begin
         exp_t e;
         total++;
         a_seen++;
         if (qa.size() == 0) begin
            $display("FAIL a_unexpected: got first=%0d second=%0d with nothing outstanding",
                     a_first_idx, a_second_idx);
         end else begin
            e = qa.pop_front();
            if ({1'b0, a_first_idx} !== e.fi || a_first_none !== e.fn ||
                {1'b0, a_second_idx} !== e.si || a_second_none !== e.sn) begin
               $display("FAIL a_result vec=%h: got %0d/%b %0d/%b, want %0d/%b %0d/%b",
                        e.v[7:0], a_first_idx, a_first_none, a_second_idx, a_second_none,
                        e.fi, e.fn, e.si, e.sn);
            end else begin
               passed++;
            end
`ifdef PRIO2_POPCNT_EN
            total++;
            if ({1'b0, a_popcnt} !== e.pc)
               $display("FAIL a_popcnt vec=%h: got %0d, want %0d", e.v[7:0], a_popcnt, e.pc);
            else passed++;
`endif
         end
      end
   end

   // Output monitor, instance b.
   always @(negedge clk) begin
      if (reset_n && b_out_valid && b_out_ready) begin
         exp_t e;
         total++;
         b_seen++;
         if (qb.size() == 0) begin
            $display("FAIL b_unexpected: got first=%0d second=%0d with nothing outstanding",
                     b_first_idx, b_second_idx);
         end else begin
            e = qb.pop_front();
            if (b_first_idx !== e.fi || b_first_none !== e.fn ||
                b_second_idx !== e.si || b_second_none !== e.sn) begin
               $display("FAIL b_result vec=%h: got %0d/%b %0d/%b, want %0d/%b %0d/%b",
                        e.v, b_first_idx, b_first_none, b_second_idx, b_second_none,
                        e.fi, e.fn, e.si, e.sn);
            end else begin
               passed++;
            end
`ifdef PRIO2_POPCNT_EN
            total++;
            if (b_popcnt !== e.pc)
               $display("FAIL b_popcnt vec=%h: got %0d, want %0d", e.v, b_popcnt, e.pc);
            else passed++;
`endif
         end
      end
   end

   // Drivers: called just after a rising edge, return just after the
   // rising edge on which the vector was accepted, leaving valid high.
   task automatic send_a(input logic [7:0] v);
      int n;
      a_in_vec   = v;
      a_in_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!a_in_ready && n < 200);
      if (!a_in_ready) begin
         total++;
         $display("FAIL a_send_timeout vec=%h: in_ready=%b, want 1", v, a_in_ready);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_b(input logic [15:0] v);
      int n;
      b_in_vec   = v;
      b_in_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!b_in_ready && n < 200);
      if (!b_in_ready) begin
         total++;
         $display("FAIL b_send_timeout vec=%h: in_ready=%b, want 1", v, b_in_ready);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_a();
      a_in_valid = 1'b0;
      a_in_vec   = 'x;
   endtask

   task automatic idle_b();
      b_in_valid = 1'b0;
      b_in_vec   = 'x;
   endtask

   // Wait (bounded) until every expected result of one instance has appeared.
   task automatic drain(input bit which_b);
      int n;
      n = 0;
      while ((which_b ? qb.size() : qa.size()) != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      #1;
      total++;
      if ((which_b ? qb.size() : qa.size()) != 0)
         $display("FAIL drain_%s: %0d results outstanding, want 0", which_b ? "b" : "a",
                  which_b ? qb.size() : qa.size());
      else passed++;
   endtask

   task automatic test_reset();
      #12;
      total++;
      if (a_out_valid !== 1'b0 || a_first_none !== 1'b1 || a_second_none !== 1'b1 ||
          a_first_idx !== 3'd0 || a_second_idx !== 3'd0)
         $display("FAIL reset_values: got valid=%b fn=%b sn=%b fi=%0d si=%0d, want 0 1 1 0 0",
                  a_out_valid, a_first_none, a_second_none, a_first_idx, a_second_idx);
      else passed++;
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      total++;
      if (a_in_ready !== 1'b1) $display("FAIL ready_after_reset: got %b, want 1", a_in_ready);
      else passed++;

      // Fill both stages, then reset in the middle of the stream.
      a_out_ready = 1'b0;
      send_a(8'h03);
      send_a(8'h30);
      idle_a();
      total++;
      if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0)
         $display("FAIL full_pipe: got out_valid=%b in_ready=%b, want 1 0", a_out_valid, a_in_ready);
      else passed++;
      #2;
      reset_n = 1'b0;
      #1;
      total++;
      if (a_out_valid !== 1'b0 || a_first_none !== 1'b1 || a_second_none !== 1'b1)
         $display("FAIL async_reset: got valid=%b fn=%b sn=%b, want 0 1 1",
                  a_out_valid, a_first_none, a_second_none);
      else passed++;
      qa.delete();
      qb.delete();
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      total++;
      if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0)
         $display("FAIL release: got in_ready=%b out_valid=%b, want 1 0", a_in_ready, a_out_valid);
      else passed++;
      a_out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (a_out_valid !== 1'b0) $display("FAIL stale_output: got out_valid=%b, want 0", a_out_valid);
      else passed++;
   endtask

   task automatic test_basic();
      logic [7:0] vecs [4] = '{8'h25, 8'h00, 8'h80, 8'hC0};
      logic [2:0] w_fi [4] = '{3'd5, 3'd0, 3'd7, 3'd7};
      logic       w_fn [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic [2:0] w_si [4] = '{3'd2, 3'd0, 3'd0, 3'd6};
      logic       w_sn [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      a_out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send_a(vecs[i]);
         idle_a();
         total++;
         if (a_out_valid !== 1'b0) $display("FAIL latency_early vec=%h: out_valid=%b, want 0", vecs[i], a_out_valid);
         else passed++;
         @(posedge clk); #1;
         total++;
         if (a_out_valid !== 1'b1 || a_first_idx !== w_fi[i] || a_first_none !== w_fn[i] ||
             a_second_idx !== w_si[i] || a_second_none !== w_sn[i])
            $display("FAIL basic vec=%h: got v=%b %0d/%b %0d/%b, want v=1 %0d/%b %0d/%b",
                     vecs[i], a_out_valid, a_first_idx, a_first_none, a_second_idx, a_second_none,
                     w_fi[i], w_fn[i], w_si[i], w_sn[i]);
         else passed++;
      end
      drain(1'b0);
   endtask

   task automatic test_backpressure();
      int seen0;
      seen0 = a_seen;
      a_out_ready = 1'b0;
      send_a(8'h03);
      send_a(8'h30);
      a_in_vec   = 8'h81;
      a_in_valid = 1'b1;
      total++;
      if (a_in_ready !== 1'b0) $display("FAIL bp_ready_drop: got %b, want 0", a_in_ready);
      else passed++;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         total++;
         if (a_out_valid !== 1'b1 || a_first_idx !== 3'd1 || a_second_idx !== 3'd0 ||
             a_first_none !== 1'b0 || a_second_none !== 1'b0 || a_in_ready !== 1'b0)
            $display("FAIL bp_hold cycle %0d: got v=%b %0d %0d rdy=%b, want v=1 1 0 rdy=0",
                     i, a_out_valid, a_first_idx, a_second_idx, a_in_ready);
         else passed++;
      end
      a_out_ready = 1'b1;
      send_a(8'h81);
      idle_a();
      drain(1'b0);
      total++;
      if (a_seen - seen0 != 3) $display("FAIL bp_count: got %0d results, want 3", a_seen - seen0);
      else passed++;
   endtask

   task automatic test_lsb_first();
      logic [15:0] vecs [6] = '{16'h0000, 16'h0001, 16'h8000, 16'hFFFF, 16'hC000, 16'h0003};
      int c0;
      b_out_ready = 1'b1;
      send_b(16'h8024);
      idle_b();
      @(posedge clk); #1;
      total++;
      if (b_out_valid !== 1'b1 || b_first_idx !== 4'd2 || b_second_idx !== 4'd5 ||
          b_first_none !== 1'b0 || b_second_none !== 1'b0)
         $display("FAIL lsb_first: got v=%b %0d/%b %0d/%b, want v=1 2/0 5/0",
                  b_out_valid, b_first_idx, b_first_none, b_second_idx, b_second_none);
      else passed++;
      // Back-to-back: every send should take exactly one cycle.
      c0 = cyc;
      for (int i = 0; i < 6; i++) send_b(vecs[i]);
      for (int i = 0; i < 10; i++) send_b(16'($urandom));
      idle_b();
      total++;
      if (cyc - c0 != 16) $display("FAIL throughput: 16 sends took %0d cycles, want 16", cyc - c0);
      else passed++;
      drain(1'b1);
   endtask

   task automatic test_random_stall();
      bit done;
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 40; i++) send_a(8'($urandom));
            idle_a();
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk); #1;
               a_out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      a_out_ready = 1'b1;
      drain(1'b0);
   endtask

`ifdef PRIO2_POPCNT_EN
   task automatic test_popcnt();
      a_out_ready = 1'b1;
      send_a(8'hB6);
      idle_a();
      @(posedge clk); #1;
      total++;
      if (a_popcnt !== 4'd5 || a_first_idx !== 3'd7 || a_second_idx !== 3'd5)
         $display("FAIL popcnt_b6: got cnt=%0d first=%0d second=%0d, want 5 7 5",
                  a_popcnt, a_first_idx, a_second_idx);
      else passed++;
      drain(1'b0);
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n     = 1'b0;
      a_in_valid  = 1'b0;
      a_in_vec    = '0;
      a_out_ready = 1'b0;
      b_in_valid  = 1'b0;
      b_in_vec    = '0;
      b_out_ready = 1'b1;
      test_reset();
      test_basic();
      test_backpressure();
      test_lsb_first();
      test_random_stall();
`ifdef PRIO2_POPCNT_EN
      test_popcnt();
`endif
      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
